piso_uart_tx: RTL and testbench

UART transmit serializer, the transmit-side counterpart of the SIPO receiver. It accepts a byte plus a framing configuration and assembles a frame: start bit, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits. It shifts the frame out on data_tx, holding each bit for OVERSAMPLE cycles of the 16x oversampled baud clock. It sits between the APB-side TX holding register and the serial pin.

---
 rtl/piso_uart_tx_if.sv | 21 ++
 rtl/piso_uart_tx.sv | 146 ++++++++++++++
 tb/tb_piso_uart_tx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_uart_tx_if.sv
// Handshake and serial-side signals of the UART transmit serializer.
// The master drives the byte and framing request; the slave drives the line and status.
interface piso_uart_tx_if;
  logic       send;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_tx;
  logic       active_flag;
  logic       done_flag;

  modport master (
    output send, data_in, parity_type, stop_bits,
    input  data_tx, active_flag, done_flag
  );

  modport slave (
    input  send, data_in, parity_type, stop_bits,
    output data_tx, active_flag, done_flag
  );
endinterface

// File: rtl/piso_uart_tx.sv
// UART transmit serializer: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Each bit is held for OVERSAMPLE baud_clk cycles; every output comes straight from a flop.
module piso_uart_tx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CNT_W      = 4
) (
  input logic             baud_clk,
  input logic             reset,
  piso_uart_tx_if.slave   bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       idx_nxt;
  logic             stop_half_q, stop_half_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       ptype_q, ptype_d;
  logic             stop2_q, stop2_d;
  logic             tx_q, tx_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             cnt_last;
  logic             par_en;
  logic             par_bit;

  assign cnt_last = (cnt_q == CNT_W'(OVERSAMPLE - 1));
  assign idx_nxt  = idx_q + 3'd1;
  assign par_en   = (ptype_q == 2'b01) || (ptype_q == 2'b10);
  // Even parity is the XOR of the byte; odd parity is its inverse.
  assign par_bit  = (ptype_q == 2'b01) ? ~(^data_q) : (^data_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_last ? '0 : cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    stop_half_d = stop_half_q;
    data_d      = data_q;
    ptype_d     = ptype_q;
    stop2_d     = stop2_q;
    tx_d        = tx_q;
    active_d    = active_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d    = '0;
        tx_d     = 1'b1;
        active_d = 1'b0;
        if (bus.send) begin
          data_d   = bus.data_in;
          ptype_d  = bus.parity_type;
          stop2_d  = bus.stop_bits;
          state_d  = StStart;
          tx_d     = 1'b0;
          active_d = 1'b1;
        end
      end
      StStart: begin
        if (cnt_last) begin
          state_d = StData;
          idx_d   = 3'd0;
          tx_d    = data_q[0];
        end
      end
      StData: begin
        if (cnt_last) begin
          if (idx_q == 3'd7) begin
            stop_half_d = 1'b0;
            if (par_en) begin
              state_d = StParity;
              tx_d    = par_bit;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_nxt;
            tx_d  = data_q[idx_nxt];
          end
        end
      end
      StParity: begin
        if (cnt_last) begin
          state_d     = StStop;
          stop_half_d = 1'b0;
          tx_d        = 1'b1;
        end
      end
      StStop: begin
        if (cnt_last) begin
          if (stop2_q && !stop_half_q) begin
            stop_half_d = 1'b1;
          end else begin
            state_d  = StIdle;
            active_d = 1'b0;
            done_d   = 1'b1;
            tx_d     = 1'b1;
          end
        end
      end
      default: begin
        state_d  = StIdle;
        tx_d     = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      stop_half_q <= 1'b0;
      data_q      <= 8'd0;
      ptype_q     <= 2'd0;
      stop2_q     <= 1'b0;
      tx_q        <= 1'b1;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stop_half_q <= stop_half_d;
      data_q      <= data_d;
      ptype_q     <= ptype_d;
      stop2_q     <= stop2_d;
      tx_q        <= tx_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

  assign bus.data_tx     = tx_q;
  assign bus.active_flag = active_q;
  assign bus.done_flag   = done_q;

endmodule

// File: tb/tb_piso_uart_tx.sv
// Self-checking bench for piso_uart_tx: directed and random frames against a bit-list model.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_piso_uart_tx;
  localparam int OS = 16;

  logic baud_clk = 1'b0;
  logic reset    = 1'b1;
  int   errors   = 0;
  int   checks   = 0;
  bit   exp_q[$];

  piso_uart_tx_if tb_if ();

  piso_uart_tx #(.OVERSAMPLE(OS), .CNT_W(4)) dut (
    .baud_clk (baud_clk),
    .reset    (reset),
    .bus      (tb_if.slave)
  );

  always #5 baud_clk = ~baud_clk;

  // Expected line bits of one frame; returns the frame length in cycles.
  function automatic int build_frame(input logic [7:0] d, input logic [1:0] pt, input logic sb);
    int ones;
    ones = $countones(d);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pt == 2'b10) exp_q.push_back(bit'(ones % 2));
    if (pt == 2'b01) exp_q.push_back(bit'(1 - (ones % 2)));
    exp_q.push_back(1'b1);
    if (sb) exp_q.push_back(1'b1);
    return exp_q.size() * OS;
  endfunction

  // Presents a request on the falling edge and returns 1 unit after the accepting rising edge.
  task automatic start_frame(input logic [7:0] d, input logic [1:0] pt, input logic sb,
                             input bit hold);
    @(negedge baud_clk);
    tb_if.data_in     = d;
    tb_if.parity_type = pt;
    tb_if.stop_bits   = sb;
    tb_if.send        = 1'b1;
    @(posedge baud_clk);
    #1;
    if (!hold) tb_if.send = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge baud_clk);
    #1;
    checks++;
    if (tb_if.data_tx !== 1'b1 || tb_if.active_flag !== 1'b0 || tb_if.done_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: tx/act/done=%b%b%b required 100",
               tb_if.data_tx, tb_if.active_flag, tb_if.done_flag);
    end
    @(negedge baud_clk);
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge baud_clk);
      #1;
      checks++;
      if (tb_if.data_tx !== 1'b1 || tb_if.active_flag !== 1'b0 || tb_if.done_flag !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: tx/act/done=%b%b%b required 100",
                 k, tb_if.data_tx, tb_if.active_flag, tb_if.done_flag);
      end
    end
  endtask

  task automatic test_frame(input string name, input logic [7:0] d, input logic [1:0] pt,
                            input logic sb, input int req_len);
    int len;
    logic exp_tx;
    len = build_frame(d, pt, sb);
    checks++;
    if (len !== req_len) begin
      errors++;
      $display("FAIL %s_len: model %0d required %0d", name, len, req_len);
    end
    start_frame(d, pt, sb, 1'b0);
    for (int k = 0; k <= len + 1; k++) begin
      if (k > 0) begin
        @(posedge baud_clk);
        #1;
      end
      exp_tx = (k < len) ? exp_q[k / OS] : 1'b1;
      checks++;
      if (tb_if.data_tx !== exp_tx || tb_if.active_flag !== (k < len) ||
          tb_if.done_flag !== (k == len)) begin
        errors++;
        $display("FAIL %s cycle N+%0d: tx/act/done=%b%b%b required %b%b%b", name, k,
                 tb_if.data_tx, tb_if.active_flag, tb_if.done_flag,
                 exp_tx, k < len, k == len);
      end
    end
  endtask

  task automatic test_ignored_send();
    int len;
    logic exp_tx;
    len = build_frame(8'h5A, 2'b10, 1'b0);
    start_frame(8'h5A, 2'b10, 1'b0, 1'b0);
    for (int k = 0; k <= len + 30; k++) begin
      if (k > 0) begin
        @(posedge baud_clk);
        #1;
      end
      if (k == 40) begin
        tb_if.send        = 1'b1;
        tb_if.data_in     = 8'h3C;
        tb_if.parity_type = 2'b01;
        tb_if.stop_bits   = 1'b1;
      end
      if (k == 41) tb_if.send = 1'b0;
      exp_tx = (k < len) ? exp_q[k / OS] : 1'b1;
      checks++;
      if (tb_if.data_tx !== exp_tx || tb_if.active_flag !== (k < len) ||
          tb_if.done_flag !== (k == len)) begin
        errors++;
        $display("FAIL ignored_send cycle N+%0d: tx/act/done=%b%b%b required %b%b%b", k,
                 tb_if.data_tx, tb_if.active_flag, tb_if.done_flag,
                 exp_tx, k < len, k == len);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [1:0] pt;
    logic       sb;
    int         len;
    logic       exp_tx;
    for (int f = 0; f < 6; f++) begin
      d   = 8'($urandom);
      pt  = 2'($urandom_range(3, 0));
      sb  = 1'($urandom_range(1, 0));
      len = build_frame(d, pt, sb);
      start_frame(d, pt, sb, 1'b0);
      for (int k = 0; k <= len; k++) begin
        if (k > 0) begin
          @(posedge baud_clk);
          #1;
        end
        if (k == 20) tb_if.data_in = ~d;
        exp_tx = (k < len) ? exp_q[k / OS] : 1'b1;
        checks++;
        if (tb_if.data_tx !== exp_tx || tb_if.active_flag !== (k < len) ||
            tb_if.done_flag !== (k == len)) begin
          errors++;
          $display("FAIL random d=%h pt=%b sb=%b cycle N+%0d: tx/act/done=%b%b%b required %b%b%b",
                   d, pt, sb, k, tb_if.data_tx, tb_if.active_flag, tb_if.done_flag,
                   exp_tx, k < len, k == len);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int   len1;
    int   len2;
    logic exp_tx;
    len1 = build_frame(8'hC3, 2'b00, 1'b0);
    start_frame(8'hC3, 2'b00, 1'b0, 1'b1);
    for (int k = 0; k <= len1; k++) begin
      if (k > 0) begin
        @(posedge baud_clk);
        #1;
      end
      if (k == 100) begin
        tb_if.data_in     = 8'h96;
        tb_if.parity_type = 2'b01;
        tb_if.stop_bits   = 1'b1;
      end
      exp_tx = (k < len1) ? exp_q[k / OS] : 1'b1;
      checks++;
      if (tb_if.data_tx !== exp_tx || tb_if.active_flag !== (k < len1) ||
          tb_if.done_flag !== (k == len1)) begin
        errors++;
        $display("FAIL b2b_first cycle N+%0d: tx/act/done=%b%b%b required %b%b%b", k,
                 tb_if.data_tx, tb_if.active_flag, tb_if.done_flag,
                 exp_tx, k < len1, k == len1);
      end
    end
    // send still high: the second frame starts on the very next edge
    len2 = build_frame(8'h96, 2'b01, 1'b1);
    for (int k = 0; k <= len2; k++) begin
      @(posedge baud_clk);
      #1;
      if (k == 0) tb_if.send = 1'b0;
      exp_tx = (k < len2) ? exp_q[k / OS] : 1'b1;
      checks++;
      if (tb_if.data_tx !== exp_tx || tb_if.active_flag !== (k < len2) ||
          tb_if.done_flag !== (k == len2)) begin
        errors++;
        $display("FAIL b2b_second cycle M+%0d: tx/act/done=%b%b%b required %b%b%b", k,
                 tb_if.data_tx, tb_if.active_flag, tb_if.done_flag,
                 exp_tx, k < len2, k == len2);
      end
    end
  endtask

  task automatic test_reset_abort();
    start_frame(8'h00, 2'b10, 1'b0, 1'b0);
    repeat (40) @(posedge baud_clk);
    #1;
    checks++;
    if (tb_if.data_tx !== 1'b0 || tb_if.active_flag !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: tx/act=%b%b required 01", tb_if.data_tx, tb_if.active_flag);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tb_if.data_tx !== 1'b1 || tb_if.active_flag !== 1'b0 || tb_if.done_flag !== 1'b0) begin
      errors++;
      $display("FAIL abort_immediate: tx/act/done=%b%b%b required 100",
               tb_if.data_tx, tb_if.active_flag, tb_if.done_flag);
    end
    repeat (2) @(posedge baud_clk);
    @(negedge baud_clk);
    reset = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge baud_clk);
      #1;
      checks++;
      if (tb_if.data_tx !== 1'b1 || tb_if.active_flag !== 1'b0 || tb_if.done_flag !== 1'b0) begin
        errors++;
        $display("FAIL abort_after cycle %0d: tx/act/done=%b%b%b required 100",
                 k, tb_if.data_tx, tb_if.active_flag, tb_if.done_flag);
      end
    end
  endtask

  initial begin
    tb_if.send        = 1'b0;
    tb_if.data_in     = 8'h00;
    tb_if.parity_type = 2'b00;
    tb_if.stop_bits   = 1'b0;
    test_reset();
    test_frame("basic_a5", 8'hA5, 2'b10, 1'b0, 176);
    test_frame("odd_2stop", 8'h07, 2'b01, 1'b1, 192);
    test_frame("no_parity", 8'hFF, 2'b00, 1'b0, 160);
    test_frame("ptype11", 8'h81, 2'b11, 1'b1, 176);
    test_ignored_send();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
